// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS program-counter logic:
//   - next-PC source encodings (PC_SEQ / PC_BR / PC_J / PC_JR)
//   - PC sequencer FSM state type
//   - default reset and exception vectors
// -----------------------------------------------------------------------------
package mips_pkg;

  // Next-PC source select encodings.
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_J   = 2'b10;
  localparam logic [1:0] PC_JR  = 2'b11;

  // RUN: PC follows the selected source.
  // HOLD: a redirect arrived during a stall and is parked in pend_pc.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } pc_state_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/pc_target_calc.sv
// -----------------------------------------------------------------------------
// pc_target_calc
// Purely combinational next-PC former.
//
// Ports:
//   pc           in   ADDR_W  current PC
//   sel          in   2       next-PC source (PC_SEQ/PC_BR/PC_J/PC_JR)
//   branch_taken in   1       branch condition, used only when sel=PC_BR
//   imm          in   IMM_W   branch offset in words
//   jump_index   in   JIDX_W  jump instruction index field
//   jr_target    in   ADDR_W  register value for jump-register
//   pc_plus4     out  ADDR_W  pc + 4
//   next_pc      out  ADDR_W  selected next PC
//   redirect     out  1       selected source is not the sequential PC
//   misalign     out  1       jump-register replaced by EXC_VECTOR
//
// Optional feature macro: MISALIGN_TRAP_EN. When defined, a jump-register to a
// target with non-zero low bits is replaced by EXC_VECTOR and flagged on
// misalign. When undefined, misalign is constant 0 and jr_target is verbatim.
// -----------------------------------------------------------------------------
module pc_target_calc
  import mips_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                JIDX_W     = 26,
  parameter int                IMM_W      = 16,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEFAULT_EXC_VECTOR)
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [1:0]        sel,
  input  logic              branch_taken,
  input  logic [IMM_W-1:0]  imm,
  input  logic [JIDX_W-1:0] jump_index,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] next_pc,
  output logic              redirect,
  output logic              misalign
);

  logic [ADDR_W-1:0] imm_sext;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] j_target;

  // All additions wrap modulo 2^ADDR_W.
  assign pc_plus4  = pc + ADDR_W'(4);
  assign imm_sext  = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign br_target = pc_plus4 + {imm_sext[ADDR_W-3:0], 2'b00};
  // Region bits come from pc_plus4, not pc, so a jump in the delay-slot
  // position at the end of a 256 MB region lands in the next region.
  assign j_target  = {pc_plus4[ADDR_W-1:JIDX_W+2], jump_index, 2'b00};

`ifdef MISALIGN_TRAP_EN
  assign misalign = (sel == PC_JR) && (jr_target[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; an unassigned path in always_comb would infer a latch.
    next_pc  = pc_plus4;
    redirect = 1'b0;
    case (sel)
      PC_BR: begin
        // A not-taken branch is just the sequential PC, not a redirect.
        if (branch_taken) begin
          next_pc  = br_target;
          redirect = 1'b1;
        end
      end
      PC_J: begin
        next_pc  = j_target;
        redirect = 1'b1;
      end
      PC_JR: begin
        next_pc  = misalign ? EXC_VECTOR : jr_target;
        redirect = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program-counter unit for the MIPS datapath: holds the PC register, the
// RUN/HOLD stall FSM and the pending-redirect register. Target arithmetic
// lives in pc_target_calc.
//
// Ports:
//   clk              in   1       clock, rising edge
//   reset            in   1       synchronous active-high reset
//   stall            in   1       hold the PC
//   sel              in   2       next-PC source (00 seq,01 br,10 j,11 jr)
//   branch_taken     in   1       branch condition, meaningful when sel=01
//   imm              in   IMM_W   branch offset in words
//   jump_index       in   JIDX_W  jump instruction index field
//   jr_target        in   ADDR_W  register value for jump-register
//   pc               out  ADDR_W  current PC
//   pc_plus4         out  ADDR_W  pc + 4 (combinational)
//   redirect_pending out  1       a redirect is parked waiting for the stall
//   trap             out  1       one-cycle misaligned jump-register pulse
//
// Optional feature macro: MISALIGN_TRAP_EN. When undefined the trap source
// is constant 0, so trap is held at 0 and its registers reduce to constants.
// -----------------------------------------------------------------------------
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                JIDX_W       = 26,
  parameter int                IMM_W        = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEFAULT_EXC_VECTOR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [1:0]        sel,
  input  logic              branch_taken,
  input  logic [IMM_W-1:0]  imm,
  input  logic [JIDX_W-1:0] jump_index,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              redirect_pending,
  output logic              trap
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              pend_trap_q, pend_trap_d;
  logic              trap_q, trap_d;

  logic [ADDR_W-1:0] next_pc;
  logic              redirect;
  logic              misalign;

  pc_target_calc #(
    .ADDR_W     (ADDR_W),
    .JIDX_W     (JIDX_W),
    .IMM_W      (IMM_W),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_calc (
    .pc           (pc_q),
    .sel          (sel),
    .branch_taken (branch_taken),
    .imm          (imm),
    .jump_index   (jump_index),
    .jr_target    (jr_target),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc),
    .redirect     (redirect),
    .misalign     (misalign)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    pend_trap_d = pend_trap_q;
    trap_d      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!stall) begin
          pc_d   = next_pc;
          trap_d = misalign;
        end else if (redirect) begin
          // Capture the fully-resolved target (including any trap
          // substitution) so later operand changes cannot alter it.
          pend_pc_d   = next_pc;
          pend_trap_d = misalign;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Redirects arriving while parked are younger and are dropped;
        // sel is also ignored on the release cycle.
        if (!stall) begin
          pc_d        = pend_pc_q;
          trap_d      = pend_trap_q;
          pend_trap_d = 1'b0;
          state_d     = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_VECTOR;
      pend_pc_q   <= RESET_VECTOR;
      pend_trap_q <= 1'b0;
      trap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      pend_trap_q <= pend_trap_d;
      trap_q      <= trap_d;
    end
  end

  assign pc               = pc_q;
  assign redirect_pending = (state_q == ST_HOLD);
  assign trap             = trap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed-vector bench with a scoreboard. The driver applies one vector per
// cycle on the falling edge and queues the state expected after the next
// rising edge; an independent monitor samples shortly after each rising edge,
// pops the queue and compares pc, pc_plus4, redirect_pending and trap.
// Build with +define+MISALIGN_TRAP_EN to exercise the optional trap.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  sel;
  logic        branch_taken;
  logic [15:0] imm;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect_pending;
  logic        trap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        rp;
    logic        trap;
  } exp_t;

  exp_t sb_q[$];

`ifdef MISALIGN_TRAP_EN
  localparam logic [31:0] EXP_JR   = 32'h0000_0080;
  localparam logic        EXP_TRAP = 1'b1;
`else
  localparam logic [31:0] EXP_JR   = 32'h0000_1002;
  localparam logic        EXP_TRAP = 1'b0;
`endif

  pc_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .sel              (sel),
    .branch_taken     (branch_taken),
    .imm              (imm),
    .jump_index       (jump_index),
    .jr_target        (jr_target),
    .pc               (pc),
    .pc_plus4         (pc_plus4),
    .redirect_pending (redirect_pending),
    .trap             (trap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: one expectation per cycle, sampled 2 time units after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.name, ".pc"},       pc,                        e.pc);
        check({e.name, ".pc_plus4"}, pc_plus4,                  e.pc + 32'd4);
        check({e.name, ".rp"},       {31'd0, redirect_pending}, {31'd0, e.rp});
        check({e.name, ".trap"},     {31'd0, trap},             {31'd0, e.trap});
      end
    end
  end

  task automatic step(input logic r, input logic st, input logic [1:0] s,
                      input logic bt, input logic [15:0] im,
                      input logic [25:0] ji, input logic [31:0] jr,
                      input logic [31:0] epc, input logic erp,
                      input logic etrap, input string nm);
    exp_t e;
    @(negedge clk);
    reset        = r;
    stall        = st;
    sel          = s;
    branch_taken = bt;
    imm          = im;
    jump_index   = ji;
    jr_target    = jr;
    e.name = nm;
    e.pc   = epc;
    e.rp   = erp;
    e.trap = etrap;
    sb_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; sel = 2'b00; branch_taken = 1'b0;
    imm = '0; jump_index = '0; jr_target = '0;

    //   rst st  sel    bt  imm       ji        jr             exp pc        rp    trap
    step(1, 0, 2'b00, 0, 16'h0,    26'h0,    32'h0,         32'h0,        0, 0, "reset");
    step(0, 0, 2'b00, 0, 16'h0,    26'h0,    32'h0,         32'h4,        0, 0, "seq1");
    step(0, 0, 2'b00, 0, 16'h0,    26'h0,    32'h0,         32'h8,        0, 0, "seq2");
    step(0, 0, 2'b00, 0, 16'h0,    26'h0,    32'h0,         32'hC,        0, 0, "seq3");
    // Branch taken / not taken from 0x0040_0010.
    step(0, 0, 2'b11, 0, 16'h0,    26'h0,    32'h0040_0010, 32'h0040_0010, 0, 0, "jr_setup1");
    step(0, 0, 2'b01, 1, 16'hFFFE, 26'h0,    32'h0,         32'h0040_000C, 0, 0, "br_taken");
    step(0, 0, 2'b11, 0, 16'h0,    26'h0,    32'h0040_0010, 32'h0040_0010, 0, 0, "jr_setup2");
    step(0, 0, 2'b01, 0, 16'hFFFE, 26'h0,    32'h0,         32'h0040_0014, 0, 0, "br_not_taken");
    // Jump keeps region bits from pc_plus4.
    step(0, 0, 2'b11, 0, 16'h0,    26'h0,    32'h1000_0000, 32'h1000_0000, 0, 0, "jr_setup3");
    step(0, 0, 2'b10, 0, 16'h0,    26'h40,   32'h0,         32'h1000_0100, 0, 0, "jump");
    // Stall: first redirect wins, later one dropped, sel ignored on release.
    step(1, 0, 2'b00, 0, 16'h0,    26'h0,    32'h0,         32'h0,        0, 0, "reset2");
    step(0, 1, 2'b10, 0, 16'h0,    26'h1,    32'h0,         32'h0,        1, 0, "stall_jump");
    step(0, 1, 2'b01, 1, 16'h5,    26'h0,    32'h0,         32'h0,        1, 0, "stall_branch");
    step(0, 1, 2'b00, 0, 16'h0,    26'h0,    32'h0,         32'h0,        1, 0, "stall_seq");
    step(0, 0, 2'b01, 1, 16'h10,   26'h0,    32'h0,         32'h4,        0, 0, "release");
    step(0, 0, 2'b00, 0, 16'h0,    26'h0,    32'h0,         32'h8,        0, 0, "after_release");
    // Stall without redirect stays in RUN (not-taken branch is no redirect).
    step(0, 1, 2'b00, 0, 16'h0,    26'h0,    32'h0,         32'h8,        0, 0, "stall_noredir");
    step(0, 1, 2'b01, 0, 16'h7,    26'h0,    32'h0,         32'h8,        0, 0, "stall_br_nt");
    step(0, 0, 2'b00, 0, 16'h0,    26'h0,    32'h0,         32'hC,        0, 0, "resume");
    // Wrap-around.
    step(0, 0, 2'b11, 0, 16'h0,    26'h0,    32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, "jr_top");
    step(0, 0, 2'b00, 0, 16'h0,    26'h0,    32'h0,         32'h0,        0, 0, "wrap");
    step(0, 0, 2'b00, 0, 16'h0,    26'h0,    32'h0,         32'h4,        0, 0, "post_wrap");
    // Reset while in HOLD discards the pending redirect.
    step(0, 1, 2'b10, 0, 16'h0,    26'h10,   32'h0,         32'h4,        1, 0, "hold_enter");
    step(1, 1, 2'b10, 0, 16'h0,    26'h10,   32'h0,         32'h0,        0, 0, "reset_in_hold");
    step(0, 0, 2'b00, 0, 16'h0,    26'h0,    32'h0,         32'h4,        0, 0, "pend_discarded");
    // Misaligned jump-register, direct and captured during a stall.
    step(0, 0, 2'b11, 0, 16'h0,    26'h0,    32'h0000_1002, EXP_JR,       0, EXP_TRAP, "jr_misalign");
    step(0, 0, 2'b00, 0, 16'h0,    26'h0,    32'h0,         EXP_JR + 4,   0, 0, "trap_pulse_end");
    step(0, 1, 2'b11, 0, 16'h0,    26'h0,    32'h0000_1002, EXP_JR + 4,   1, 0, "jr_mis_stall");
    step(0, 0, 2'b00, 0, 16'h0,    26'h0,    32'h0,         EXP_JR,       0, EXP_TRAP, "jr_mis_release");
    step(0, 0, 2'b00, 0, 16'h0,    26'h0,    32'h0,         EXP_JR + 4,   0, 0, "trap_end2");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
